// File: rtl/wt_cache_pkg.sv
// Shared types for the write-through cache memory arbiter.
// Request/return structs are sized by the MemArb* constants below; the
// wt_mem_arbiter width parameters default to these values and must match them.
package wt_cache_pkg;

  localparam int unsigned MemArbAddrWidth = 64;
  localparam int unsigned MemArbDataWidth = 64;
  localparam int unsigned MemArbLineWidth = 128;
  localparam int unsigned MemArbTxIdWidth = 2;

  // Source encoding carried in the MSB of the memory-side transaction ID.
  localparam logic SRC_ICACHE = 1'b0;
  localparam logic SRC_DCACHE = 1'b1;

  typedef struct packed {
    logic [MemArbAddrWidth-1:0]   addr;
    logic                         we;
    logic [MemArbDataWidth/8-1:0] be;
    logic [MemArbDataWidth-1:0]   wdata;
    logic [MemArbTxIdWidth:0]     id;
  } mem_arb_req_t;

  typedef struct packed {
    logic [MemArbTxIdWidth-1:0] tid;
    logic [MemArbLineWidth-1:0] data;
    logic                       err;
  } mem_arb_rtrn_t;

  // Memory-side ID: source bit on top, cache transaction ID below.
  function automatic logic [MemArbTxIdWidth:0] mem_arb_id(
    input logic                       src,
    input logic [MemArbTxIdWidth-1:0] tid
  );
    return {src, tid};
  endfunction

endpackage

// File: rtl/wt_mem_rr_arb.sv
// Two-input round-robin arbiter. The pointer names the source that wins a
// tie; after any grant it moves to the source that was not granted.
module wt_mem_rr_arb
  import wt_cache_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] elig_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;
  logic ptr_n;

  assign ptr_n = ~ptr_q;

  // Grant the pointer source if eligible, else the other one; steer pointer away from the winner.
  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (en_i) begin
      if (elig_i[ptr_q]) begin
        gnt_o[ptr_q] = 1'b1;
        ptr_d        = ptr_n;
      end else if (elig_i[ptr_n]) begin
        gnt_o[ptr_n] = 1'b1;
        ptr_d        = ptr_q;
      end
    end
  end

  // Pointer register, starts at the I$.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= SRC_ICACHE;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/wt_mem_arbiter.sv
// Merges I$ and D$ memory requests onto one registered request channel and
// routes returns back to the originating cache.
// Optional build macro: WT_MEM_ARB_PERF_EN adds stall/full performance counters.
//
// Handshakes:
//  - Cache side: a cache holds *_req_i with stable fields until it sees
//    *_ack_o high; ack is a single-cycle pulse in the cycle the request is
//    copied into the output register.
//  - Memory side: mem_req_o is valid/ready style with mem_gnt_i as ready;
//    once mem_req_o rises every mem_* field stays stable until the cycle
//    mem_gnt_i is high, which completes the transfer.
//  - Return side: mem_rvalid_i has no backpressure and appears one cycle
//    later on the matching *_rtrn_vld_o.
module wt_mem_arbiter
  import wt_cache_pkg::*;
#(
  parameter int unsigned AddrWidth      = MemArbAddrWidth,
  parameter int unsigned DataWidth      = MemArbDataWidth,
  parameter int unsigned LineWidth      = MemArbLineWidth,
  parameter int unsigned TxIdWidth      = MemArbTxIdWidth,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  // I$ request
  input  logic                              ic_req_i,
  output logic                              ic_ack_o,
  input  logic [AddrWidth-1:0]              ic_addr_i,
  input  logic [TxIdWidth-1:0]              ic_tid_i,
  // D$ request
  input  logic                              dc_req_i,
  output logic                              dc_ack_o,
  input  logic [AddrWidth-1:0]              dc_addr_i,
  input  logic                              dc_we_i,
  input  logic [DataWidth/8-1:0]            dc_be_i,
  input  logic [DataWidth-1:0]              dc_wdata_i,
  input  logic [TxIdWidth-1:0]              dc_tid_i,
  // memory request
  output logic                              mem_req_o,
  input  logic                              mem_gnt_i,
  output logic [AddrWidth-1:0]              mem_addr_o,
  output logic                              mem_we_o,
  output logic [DataWidth/8-1:0]            mem_be_o,
  output logic [DataWidth-1:0]              mem_wdata_o,
  output logic [TxIdWidth:0]                mem_id_o,
  // memory return
  input  logic                              mem_rvalid_i,
  input  logic [TxIdWidth:0]                mem_rid_i,
  input  logic [LineWidth-1:0]              mem_rdata_i,
  input  logic                              mem_rerr_i,
  // cache returns
  output logic                              ic_rtrn_vld_o,
  output logic [TxIdWidth-1:0]              ic_rtrn_tid_o,
  output logic [LineWidth-1:0]              ic_rtrn_data_o,
  output logic                              ic_rtrn_err_o,
  output logic                              dc_rtrn_vld_o,
  output logic [TxIdWidth-1:0]              dc_rtrn_tid_o,
  output logic [LineWidth-1:0]              dc_rtrn_data_o,
  output logic                              dc_rtrn_err_o,
  output logic                              busy_o,
  // debug visibility
  output logic [0:0]                        dbg_state_o,
  output logic [$clog2(MaxOutstanding+1)-1:0] dbg_ic_cnt_o,
  output logic [$clog2(MaxOutstanding+1)-1:0] dbg_dc_cnt_o,
  output logic                              dbg_rtrn_drop_o
`ifdef WT_MEM_ARB_PERF_EN
  ,
  output logic [31:0]                       perf_stall_cycles_o,
  output logic [31:0]                       perf_full_cycles_o
`endif
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]          state_q, state_d;
  mem_arb_req_t        req_q, req_d;
  mem_arb_rtrn_t       rtrn_q, rtrn_d;
  logic                ic_rvld_q, dc_rvld_q;
  logic [CntWidth-1:0] ic_cnt_q, ic_cnt_d;
  logic [CntWidth-1:0] dc_cnt_q, dc_cnt_d;

  logic       cap_en;
  logic [1:0] elig;
  logic [1:0] gnt;
  logic       rtrn_src;
  logic       ic_dec, dc_dec;
  logic       rtrn_drop;

  // A capture is possible when the output register is empty or drains this cycle.
  assign cap_en  = ~rst_i & ((state_q == ST_IDLE) | mem_gnt_i);
  assign elig[0] = ic_req_i & (ic_cnt_q < CntMax);
  assign elig[1] = dc_req_i & (dc_cnt_q < CntMax);

  wt_mem_rr_arb u_rr_arb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (cap_en),
    .elig_i (elig),
    .gnt_o  (gnt)
  );

  assign ic_ack_o = gnt[0];
  assign dc_ack_o = gnt[1];

  // Returns only count against a source that actually has something outstanding.
  assign rtrn_src  = mem_rid_i[TxIdWidth];
  assign ic_dec    = mem_rvalid_i & (rtrn_src == SRC_ICACHE) & (ic_cnt_q != '0);
  assign dc_dec    = mem_rvalid_i & (rtrn_src == SRC_DCACHE) & (dc_cnt_q != '0);
  assign rtrn_drop = mem_rvalid_i & ~(ic_dec | dc_dec);

  // Next request register contents and FSM state.
  always_comb begin
    req_d   = req_q;
    state_d = state_q;
    if (gnt[0]) begin
      // I$ traffic is read-only, so write fields are zeroed.
      req_d.addr  = ic_addr_i;
      req_d.we    = 1'b0;
      req_d.be    = '0;
      req_d.wdata = '0;
      req_d.id    = mem_arb_id(SRC_ICACHE, ic_tid_i);
    end else if (gnt[1]) begin
      req_d.addr  = dc_addr_i;
      req_d.we    = dc_we_i;
      req_d.be    = dc_be_i;
      req_d.wdata = dc_wdata_i;
      req_d.id    = mem_arb_id(SRC_DCACHE, dc_tid_i);
    end
    if (|gnt) begin
      state_d = ST_HOLD;
    end else if (mem_gnt_i) begin
      state_d = ST_IDLE;
    end
  end

  // Outstanding counters: capture adds one, a matched return removes one.
  always_comb begin
    ic_cnt_d = ic_cnt_q;
    dc_cnt_d = dc_cnt_q;
    if (gnt[0] & ~ic_dec) begin
      ic_cnt_d = ic_cnt_q + CntOne;
    end else if (~gnt[0] & ic_dec) begin
      ic_cnt_d = ic_cnt_q - CntOne;
    end
    if (gnt[1] & ~dc_dec) begin
      dc_cnt_d = dc_cnt_q + CntOne;
    end else if (~gnt[1] & dc_dec) begin
      dc_cnt_d = dc_cnt_q - CntOne;
    end
  end

  // Return payload is shared by both caches; only the valids are demuxed.
  always_comb begin
    rtrn_d = rtrn_q;
    if (mem_rvalid_i) begin
      rtrn_d.tid  = mem_rid_i[TxIdWidth-1:0];
      rtrn_d.data = mem_rdata_i;
      rtrn_d.err  = mem_rerr_i;
    end
  end

  // State, request, return and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      rtrn_q    <= '0;
      ic_rvld_q <= 1'b0;
      dc_rvld_q <= 1'b0;
      ic_cnt_q  <= '0;
      dc_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      rtrn_q    <= rtrn_d;
      ic_rvld_q <= ic_dec;
      dc_rvld_q <= dc_dec;
      ic_cnt_q  <= ic_cnt_d;
      dc_cnt_q  <= dc_cnt_d;
    end
  end

  // Flag returns that arrive for a source with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!rtrn_drop)
        else $warning("wt_mem_arbiter: return id %0h dropped, source has nothing outstanding",
                      mem_rid_i);
    end
  end

  assign mem_req_o       = (state_q == ST_HOLD);
  assign mem_addr_o      = req_q.addr;
  assign mem_we_o        = req_q.we;
  assign mem_be_o        = req_q.be;
  assign mem_wdata_o     = req_q.wdata;
  assign mem_id_o        = req_q.id;

  assign ic_rtrn_vld_o   = ic_rvld_q;
  assign ic_rtrn_tid_o   = rtrn_q.tid;
  assign ic_rtrn_data_o  = rtrn_q.data;
  assign ic_rtrn_err_o   = rtrn_q.err;
  assign dc_rtrn_vld_o   = dc_rvld_q;
  assign dc_rtrn_tid_o   = rtrn_q.tid;
  assign dc_rtrn_data_o  = rtrn_q.data;
  assign dc_rtrn_err_o   = rtrn_q.err;

  assign busy_o          = (state_q == ST_HOLD) | (ic_cnt_q != '0) | (dc_cnt_q != '0);

  assign dbg_state_o     = state_q;
  assign dbg_ic_cnt_o    = ic_cnt_q;
  assign dbg_dc_cnt_o    = dc_cnt_q;
  assign dbg_rtrn_drop_o = rtrn_drop & ~rst_i;

`ifdef WT_MEM_ARB_PERF_EN
  logic [31:0] perf_stall_q, perf_full_q;
  logic        src_full;

  assign src_full = (ic_req_i & (ic_cnt_q == CntMax)) | (dc_req_i & (dc_cnt_q == CntMax));

  // Saturating counters for memory stalls and outstanding-limit blocking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_stall_q <= '0;
      perf_full_q  <= '0;
    end else begin
      if ((state_q == ST_HOLD) && !mem_gnt_i && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (src_full && (perf_full_q != '1)) begin
        perf_full_q <= perf_full_q + 32'd1;
      end
    end
  end

  assign perf_stall_cycles_o = perf_stall_q;
  assign perf_full_cycles_o  = perf_full_q;
`endif

endmodule
